// File: rtl/scan_mux.sv
// N-to-1 channel multiplexer with registered output, manual select or auto-scan with dwell.
// Optional per-channel enable mask when SCAN_MUX_MASK_EN is defined (adds the ch_en port).
module scan_mux #(
   parameter  int N     = 8,
   parameter  int W     = 1,
   parameter  int DWELL = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    din,
   input  logic [SELW-1:0]   sel,
   input  logic              auto,
   input  logic              hold,
`ifdef SCAN_MUX_MASK_EN
   input  logic [N-1:0]      ch_en,
`endif
   output logic [W-1:0]      dout,
   output logic [SELW-1:0]   ch,
   output logic              stb,
   output logic              wrap
);

   localparam int DW = $clog2(DWELL + 1);

   logic [SELW-1:0] p_q, p_d, ch_q, ch_d, p_nxt;
   logic [DW-1:0]   d_q, d_d;
   logic [W-1:0]    dout_q, dout_d;
   logic            stb_q, stb_d, wrap_q, wrap_d, pend_q, pend_d;
   logic [N-1:0]    en;
   logic            sel_ok;

`ifdef SCAN_MUX_MASK_EN
   assign en = ch_en;
`else
   assign en = '1;
`endif

   assign sel_ok = (int'(sel) < N);

   function automatic logic [W-1:0] pick(input logic [N*W-1:0] v, input logic [SELW-1:0] idx);
      pick = '0;
      for (int k = 0; k < N; k++)
         if (idx == SELW'(k)) pick = v[k*W +: W];
   endfunction

   function automatic logic en_at(input logic [N-1:0] m, input logic [SELW-1:0] idx);
      en_at = 1'b0;
      for (int k = 0; k < N; k++)
         if (idx == SELW'(k)) en_at = m[k];
   endfunction

`ifdef SCAN_MUX_MASK_EN
   // Descending search so the nearest enabled channel after cur is the last one assigned.
   function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] cur, input logic [N-1:0] m);
      next_ch = cur;
      for (int k = N - 1; k >= 1; k--)
         if (m[(int'(cur) + k) % N]) next_ch = SELW'((int'(cur) + k) % N);
   endfunction
`else
   function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] cur, input logic [N-1:0] m);
      next_ch = (m != '0 && cur == SELW'(N - 1)) ? '0 : cur + SELW'(1);
   endfunction
`endif

   assign p_nxt = next_ch(p_q, en);

   always_comb begin
      p_d    = p_q;
      d_d    = d_q;
      ch_d   = ch_q;
      dout_d = '0;
      wrap_d = 1'b0;
      pend_d = 1'b0;
      if (!auto) begin
         ch_d   = sel;
         p_d    = sel_ok ? sel : '0;
         d_d    = '0;
         dout_d = (sel_ok && en_at(en, sel)) ? pick(din, sel) : '0;
      end else begin
         ch_d   = p_q;
         dout_d = en_at(en, p_q) ? pick(din, p_q) : '0;
         // pend_q marks that the pointer just wrapped; wrap fires when ch catches up.
         wrap_d = pend_q;
         if (!hold) begin
            if (d_q == DW'(DWELL - 1)) begin
               d_d    = '0;
               p_d    = p_nxt;
               pend_d = (p_nxt <= p_q);
            end else begin
               d_d = d_q + DW'(1);
            end
         end
      end
`ifdef SCAN_MUX_MASK_EN
      if (en == '0) begin
         ch_d   = ch_q;
         p_d    = p_q;
         d_d    = d_q;
         dout_d = '0;
         wrap_d = 1'b0;
         pend_d = 1'b0;
      end
`endif
      stb_d = (ch_d != ch_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q    <= '0;
         d_q    <= '0;
         ch_q   <= '0;
         dout_q <= '0;
         stb_q  <= 1'b0;
         wrap_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         d_q    <= d_d;
         ch_q   <= ch_d;
         dout_q <= dout_d;
         stb_q  <= stb_d;
         wrap_q <= wrap_d;
         pend_q <= pend_d;
      end
   end

   assign dout = dout_q;
   assign ch   = ch_q;
   assign stb  = stb_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux (N=8, W=1, DWELL=4); masking checks only when SCAN_MUX_MASK_EN is defined.
module tb_scan_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'hFF;
  logic [2:0] sel = '0;
  logic       auto = 1'b0;
  logic       hold = 1'b0;
`ifdef SCAN_MUX_MASK_EN
  logic [7:0] ch_en = 8'hFF;
`endif
  logic       dout;
  logic [2:0] ch;
  logic       stb;
  logic       wrap;

  scan_mux #(.N(8), .W(1), .DWELL(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .sel  (sel),
    .auto (auto),
    .hold (hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_en(ch_en),
`endif
    .dout (dout),
    .ch   (ch),
    .stb  (stb),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       d;
    logic [2:0] c;
    logic       s;
    logic       w;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  // One expectation per rising edge; checked on the following falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({dout, ch, stb, wrap} !== {e.d, e.c, e.s, e.w}) begin
        fails++;
        $display("FAIL %s: got dout=%0d ch=%0d stb=%0d wrap=%0d, want dout=%0d ch=%0d stb=%0d wrap=%0d",
                 e.nm, dout, ch, stb, wrap, e.d, e.c, e.s, e.w);
      end
    end
  end

  initial begin
    #20000;
    tests++;
    fails++;
    $display("FAIL watchdog: wait for end of sequence expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic st(input int n, input logic d, input logic [2:0] c, input logic s, input logic w,
                    input string nm);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.d = d; x.c = c; x.s = (i == 0) ? s : 1'b0; x.w = (i == 0) ? w : 1'b0; x.nm = nm;
      q.push_back(x);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: reset, then manual select
    st(2, 0, 0, 0, 0, "reset");
    tests++;
    if (dout !== 1'b0 || ch !== 3'd0 || stb !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got dout=%0d ch=%0d stb=%0d wrap=%0d, want all 0",
               dout, ch, stb, wrap);
    end
    rst = 0; sel = 4; din = 8'b00010011;
    st(2, 1, 4, 1, 0, "man_sel4");
    // 2: manual changes
    din = 8'b10100001; sel = 7;
    st(2, 1, 7, 1, 0, "man_sel7");
    sel = 1;
    st(2, 0, 1, 1, 0, "man_sel1");
    sel = 5;
    st(1, 1, 5, 1, 0, "man_sel5");
    // 3: auto scan from last manual select
    sel = 6;
    st(1, 0, 6, 1, 0, "man_sel6");
    auto = 1;
    st(4, 0, 6, 0, 0, "auto_ch6");
    st(4, 1, 7, 1, 0, "auto_ch7");
    st(4, 1, 0, 1, 1, "auto_wrap_ch0");
    st(4, 0, 1, 1, 0, "auto_ch1");
    // 4: hold mid-dwell on ch2, din[2] toggled during hold
    st(2, 0, 2, 1, 0, "auto_ch2");
    hold = 1;
    st(1, 0, 2, 0, 0, "hold_ch2");
    din[2] = 1'b1;
    st(2, 1, 2, 0, 0, "hold_din_track");
    hold = 0;
    st(2, 1, 2, 0, 0, "post_hold_ch2");
    st(4, 0, 3, 1, 0, "auto_ch3");
    st(4, 0, 4, 1, 0, "auto_ch4");
    st(1, 1, 5, 1, 0, "auto_ch5");
    // 5: reset mid-scan
    rst = 1;
    st(1, 0, 0, 0, 0, "reset_midscan");
    rst = 0;
    st(4, 1, 0, 0, 0, "restart_ch0");
    st(1, 0, 1, 1, 0, "restart_ch1");
    auto = 0; sel = 7;
    st(1, 1, 7, 1, 0, "back_to_manual");
    sel = 0;
    st(1, 1, 0, 1, 0, "manual_no_wrap");
`ifdef SCAN_MUX_MASK_EN
    // 6: masking
    rst = 1; ch_en = 8'b10000101; din = 8'hFF; auto = 1;
    st(1, 0, 0, 0, 0, "mask_reset");
    rst = 0;
    st(4, 1, 0, 0, 0, "mask_ch0");
    st(4, 1, 2, 1, 0, "mask_ch2");
    st(4, 1, 7, 1, 0, "mask_ch7");
    st(1, 1, 0, 1, 1, "mask_wrap_ch0");
    ch_en = 8'h00;
    st(3, 0, 0, 0, 0, "mask_none_frozen");
`endif
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
